debug_uart: RTL and testbench

- Board-level debug/heartbeat block for the 27 MHz FPGA target.
- Drives three status LEDs from a free-running counter, each at a different blink rate.
- Periodically transmits the ASCII message "Hello! Counter: 0xHHHH" followed by CR LF on an 8N1 UART at 115200 baud. HHHH is a 16-bit message counter that increments after each message.

---
 rtl/debug_uart.sv | 138 +++++++++++++
 tb/tb_debug_uart.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart.sv
// debug_uart: heartbeat LEDs from a free-running counter plus a periodic
// "Hello! Counter: 0xHHHH\r\n" message on an 8N1 UART transmitter.
module debug_uart #(
    parameter int unsigned CLK_FREQ     = 27000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int unsigned MSG_INTERVAL = 134217728,
    parameter int unsigned LED_BASE     = 22,
    // Message-counter value after reset; non-zero only to reach the wrap quickly.
    parameter logic [15:0] MSG_CNT_INIT = 16'h0000
) (
    input  logic clk,
    input  logic rst,
    output logic led_r,
    output logic led_g,
    output logic led_b,
    output logic uart_tx
);

    localparam logic [15:0]     BIT_LAST      = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     INTERVAL_LAST = 32'(MSG_INTERVAL - 1);
    localparam logic [8*18-1:0] PREFIX        = "Hello! Counter: 0x";
    localparam logic [4:0]      LAST_BYTE     = 5'd23;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [31:0]     blink_q, blink_d;
    logic [31:0]     timer_q, timer_d;
    logic [15:0]     msg_cnt_q, msg_cnt_d;
    logic [15:0]     snap_q, snap_d;
    logic [15:0]     baud_q, baud_d;
    logic [4:0]      byte_idx_q, byte_idx_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [2:0]      led_q, led_d;
    logic            tx_q, tx_d;
    logic            req;
    logic            bit_done;
    logic [8*18-1:0] prefix_sh;
    logic [3:0]      nib;
    logic [7:0]      cur_byte;

    // Timer sits at zero on the first cycle after reset and on every wrap.
    assign req      = (timer_q == '0);
    assign bit_done = (baud_q == BIT_LAST);

    always_comb begin
        prefix_sh = PREFIX << {byte_idx_q, 3'b000};
        case (byte_idx_q)
            5'd18:   nib = snap_q[15:12];
            5'd19:   nib = snap_q[11:8];
            5'd20:   nib = snap_q[7:4];
            default: nib = snap_q[3:0];
        endcase
        if (byte_idx_q < 5'd18)       cur_byte = prefix_sh[8*18-1 -: 8];
        else if (byte_idx_q < 5'd22)  cur_byte = (nib < 4'd10) ? {4'h3, nib} : {4'h4, nib - 4'd9};
        else if (byte_idx_q == 5'd22) cur_byte = 8'h0D;
        else                          cur_byte = 8'h0A;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = START;
            START:   if (bit_done) state_d = DATA;
            DATA:    if (bit_done && bit_idx_q == 3'd7) state_d = STOP;
            STOP:    if (bit_done) state_d = (byte_idx_q == LAST_BYTE) ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        blink_d    = blink_q + 32'd1;
        timer_d    = (timer_q == INTERVAL_LAST) ? '0 : timer_q + 32'd1;
        baud_d     = (state_q == IDLE || bit_done) ? '0 : baud_q + 16'd1;
        led_d      = {blink_q[LED_BASE+2], blink_q[LED_BASE+1], blink_q[LED_BASE]};
        msg_cnt_d  = msg_cnt_q;
        snap_d     = snap_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        case (state_q)
            IDLE: if (req) begin
                snap_d     = msg_cnt_q;
                byte_idx_d = '0;
                bit_idx_d  = '0;
            end
            DATA: if (bit_done) bit_idx_d = bit_idx_q + 3'd1;
            STOP: if (bit_done) begin
                if (byte_idx_q == LAST_BYTE) msg_cnt_d = msg_cnt_q + 16'd1;
                else                         byte_idx_d = byte_idx_q + 5'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q    <= '0;
            timer_q    <= '0;
            baud_q     <= '0;
            led_q      <= '0;
            msg_cnt_q  <= MSG_CNT_INIT;
            snap_q     <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            blink_q    <= blink_d;
            timer_q    <= timer_d;
            baud_q     <= baud_d;
            led_q      <= led_d;
            msg_cnt_q  <= msg_cnt_d;
            snap_q     <= snap_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
        end
    end

    assign led_r   = led_q[0];
    assign led_g   = led_q[1];
    assign led_b   = led_q[2];
    assign uart_tx = tx_q;

endmodule

// File: tb/tb_debug_uart.sv
// tb_debug_uart: two debug_uart instances (counter from 0x0000 and from 0xFFFE) checked
// every cycle against a message-schedule model, plus a UART receiver and literal checks.
module tb_debug_uart;

    localparam int unsigned CPB      = 4;
    localparam int unsigned INTERVAL = 700;
    localparam int unsigned LB       = 4;
    localparam int unsigned MSG_CYC  = 240 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] led_r, led_g, led_b, tx;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: e = edges since reset release; acc = edge of the last accepted request.
    int unsigned e = 0;
    int unsigned acc = 0;
    bit          active = 1'b0;
    logic [15:0] snap = '0;
    logic [15:0] cnt = '0;

    int          rx_t[2];
    bit          rx_busy[2];
    logic [7:0]  rx_b[2];
    string       rx_s[2];
    string       msgs0[$];
    string       msgs1[$];

    debug_uart #(.CLK_FREQ(460800), .BAUD(115200), .MSG_INTERVAL(INTERVAL), .LED_BASE(LB)) dut (
        .clk(clk), .rst(rst), .led_r(led_r[0]), .led_g(led_g[0]), .led_b(led_b[0]), .uart_tx(tx[0])
    );

    debug_uart #(.CLK_FREQ(460800), .BAUD(115200), .MSG_INTERVAL(INTERVAL), .LED_BASE(LB),
                 .MSG_CNT_INIT(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst), .led_r(led_r[1]), .led_g(led_g[1]), .led_b(led_b[1]), .uart_tx(tx[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
        end
    endtask

    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, (s[i] < 8'h20) ? "." : s.substr(i, i)};
        return r;
    endfunction

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(act), vis(exp));
        end
    endtask

    function automatic logic [7:0] msg_byte(input int unsigned idx, input logic [15:0] v);
        string hello = "Hello! Counter: 0x";
        string hexd  = "0123456789ABCDEF";
        logic [3:0] n;
        if (idx < 18) return hello[idx];
        if (idx < 22) begin
            n = 4'(v >> (4 * (21 - idx)));
            return hexd[n];
        end
        if (idx == 22) return 8'h0D;
        return 8'h0A;
    endfunction

    // Line level t cycles into a message: start bit, 8 data bits LSB first, stop bit.
    function automatic logic wave(input int unsigned t, input logic [15:0] v);
        int unsigned pos = (t % (10 * CPB)) / CPB;
        logic [7:0] b;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b = msg_byte(t / (10 * CPB), v);
        return b[pos-1];
    endfunction

    task automatic rx_step(input int k, input logic s);
        int bitn;
        if (!rx_busy[k]) begin
            if (s == 1'b0) begin
                rx_busy[k] = 1'b1;
                rx_t[k]    = 0;
            end
        end else begin
            rx_t[k]++;
            if (rx_t[k] % CPB == CPB / 2) begin
                bitn = rx_t[k] / CPB;
                if (bitn >= 1 && bitn <= 8) rx_b[k][bitn-1] = s;
                else if (bitn == 9) begin
                    chk("rx_stop_bit", 32'(s), 32'd1);
                    rx_busy[k] = 1'b0;
                    rx_s[k] = $sformatf("%s%c", rx_s[k], rx_b[k]);
                    if (rx_b[k] == 8'h0A) begin
                        if (k == 0) msgs0.push_back(rx_s[k]);
                        else        msgs1.push_back(rx_s[k]);
                        rx_s[k] = "";
                    end
                end
            end
        end
    endtask

    task automatic step();
        bit busy;
        logic [1:0] exp_tx;
        logic [5:0] exp_led;
        logic er, eg, eb;
        @(posedge clk);
        #1;
        if (rst) begin
            e = 0;
            active = 1'b0;
            cnt = '0;
            for (int k = 0; k < 2; k++) begin
                rx_busy[k] = 1'b0;
                rx_s[k] = "";
            end
            chk("reset_tx", 32'(tx), 32'h3);
            chk("reset_led", 32'({led_b, led_g, led_r}), 32'h0);
        end else begin
            busy = active && (e <= acc + MSG_CYC);
            if ((e % INTERVAL) == 0 && !busy) begin
                active = 1'b1;
                acc = e;
                snap = cnt;
            end
            exp_tx = 2'b11;
            if (active && e >= acc + 1 && e <= acc + MSG_CYC) begin
                exp_tx[0] = wave(e - acc - 1, snap);
                exp_tx[1] = wave(e - acc - 1, snap + 16'hFFFE);
            end
            chk("uart_tx", 32'(tx), 32'(exp_tx));
            er = 1'(e >> LB);
            eg = 1'(e >> (LB + 1));
            eb = 1'(e >> (LB + 2));
            exp_led = {eb, eb, eg, eg, er, er};
            chk("leds", 32'({led_b, led_g, led_r}), 32'(exp_led));
            if (active && e == acc + MSG_CYC) cnt = cnt + 16'd1;
            rx_step(0, tx[0]);
            rx_step(1, tx[1]);
            e++;
        end
    endtask

    string exp0[4];
    string exp1[4];

    initial begin
        exp0[0] = "Hello! Counter: 0x0000\r\n";
        exp0[1] = "Hello! Counter: 0x0001\r\n";
        exp0[2] = "Hello! Counter: 0x0002\r\n";
        exp0[3] = "Hello! Counter: 0x0000\r\n";
        exp1[0] = "Hello! Counter: 0xFFFE\r\n";
        exp1[1] = "Hello! Counter: 0xFFFF\r\n";
        exp1[2] = "Hello! Counter: 0x0000\r\n";
        exp1[3] = "Hello! Counter: 0xFFFE\r\n";

        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;

        step();
        chk("lit_idle_edge0", 32'(tx), 32'h3);
        step();
        chk("lit_start_edge1", 32'(tx), 32'h0);

        while (e < 16) step();
        chk("lit_led_r_edge15", 32'(led_r), 32'h0);
        step();
        chk("lit_led_r_edge16", 32'(led_r), 32'h3);

        // Request at 700 is dropped; the next message is accepted at edge 1400.
        while (e < 1401) step();
        chk("lit_idle_edge1400", 32'(tx), 32'h3);
        step();
        chk("lit_start_edge1401", 32'(tx), 32'h0);

        // Message accepted at 4200 is in byte 5 after edge 4411.
        while (e < 4412) step();
        rst = 1'b1;
        step();
        chk("lit_midmsg_reset_tx", 32'(tx), 32'h3);
        chk("lit_midmsg_reset_led", 32'({led_b, led_g, led_r}), 32'h0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 1000; i++) step();

        chk("msg_count_dut", 32'(msgs0.size()), 32'd4);
        chk("msg_count_dut_w", 32'(msgs1.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk_str($sformatf("msg%0d_dut", i), (i < msgs0.size()) ? msgs0[i] : "", exp0[i]);
            chk_str($sformatf("msg%0d_dut_w", i), (i < msgs1.size()) ? msgs1[i] : "", exp1[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
